dsp_stream_arbiter: RTL
=======================

# dsp_stream_arbiter

Parametrised N-channel stream front end for the DSP filter chain. It generalises the fixed two-source (interpolator/decimator) input select into NUM_CH independently buffered channels. Each channel has a FIFO, and the channels are merged onto one ready/valid output by round-robin or fixed-priority arbitration. Every output word carries a channel tag. The block sits between the DUC/DDC outputs and the FIR input, and is configured through its own small register window on the same addr/write_en/wdata/rdata bus style as the memory map.

## Interface
- DATA_WIDTH, 16, sample width (signed)
- NUM_CH, 4, number of input channels (2..16)
- FIFO_DEPTH, 8, entries per channel FIFO (power of two, ≥2)
- ADDR_WIDTH, 5, register address width; must satisfy 2^ADDR_WIDTH ≥ 4+NUM_CH
- CH_W (localparam), max(1, clog2(NUM_CH)), channel tag width
- clk  in  1  single clock; all logic on its rising edge
- arst  in  1  reset, asynchronous and active-high; clears all state
- addr  in  ADDR_WIDTH  register address
- write_en  in  1  register write strobe
- wdata  in  DATA_WIDTH  register write data
- rdata  out  DATA_WIDTH  register read data, combinational from addr
- src_data_in  in  NUM_CH*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- src_valid_in  in  NUM_CH  per-channel valid
- src_ready_out  out  NUM_CH  per-channel ready
- dst_data_out  out  DATA_WIDTH  merged sample
- dst_chan_out  out  CH_W  source channel of dst_data_out
- dst_valid_out  out  1  output valid
- dst_ready_in  in  1  downstream ready
- irq  out  1  interrupt, registered

## Operation
- Registers (unlisted bits read 0, writes ignored):
  - 0x0 CTRL: bit0 EN (global enable); bit1 MODE (0 round-robin, 1 fixed priority, lowest index wins); bit2 FLUSH (write-1 pulse, reads 0).
  - 0x1 CH_EN: bits[NUM_CH-1:0] per-channel enable.
  - 0x2 STALL: bits[NUM_CH-1:0] sticky. Bit i sets when src_valid_in[i]=1 while FIFO i is full and CH_EN[i]=1. Write-1-to-clear; a set in the same cycle as a clear wins.
  - 0x3 IRQ_EN: per-channel mask.
  - 0x4+i: FIFO i level, 0..FIFO_DEPTH, read-only, zero-extended.
  - Addresses ≥ 4+NUM_CH read 0.
- src_ready_out[i] = EN & CH_EN[i] & ~full[i]. It has no dependency on the same-cycle pop (no combinational ready path). A push occurs on valid & ready.
- Output stage is a single register (OREG). A grant happens when EN=1, OREG is empty or being consumed (dst_valid_out & dst_ready_in), and at least one channel has CH_EN=1 and a non-empty FIFO.
- On a grant, the granted FIFO pops and OREG loads {data, chan}.
- Round-robin:
  - Search starts at last_grant+1 and wraps modulo NUM_CH.
  - last_grant updates only on a grant.
  - Reset value of last_grant is NUM_CH-1, so channel 0 is first.
- Fixed priority: lowest eligible index wins; last_grant still tracks the most recent grant.
- Disabled channel (CH_EN=0): FIFO contents are retained and not granted; the level stays readable.
- EN=0: no grants and all src_ready_out are low. OREG still drains normally.
- FLUSH: on the edge after the write, all FIFO levels, OREG valid and last_grant reset to their reset values. STALL, CH_EN and IRQ_EN are unaffected. This is the only case where dst_valid_out may drop without a handshake.
- irq = registered |(STALL & IRQ_EN).

## Timing
- Reset values: rdata reflects CTRL, so 0; src_ready_out=0; dst_valid_out=0; dst_data_out=0; dst_chan_out=0; irq=0; all registers 0; all FIFOs empty.
- After reset nothing flows until EN and CH_EN are written.
- Register writes take effect on the edge after write_en.
- Latency: a word pushed at edge k into an empty FIFO, with OREG free, is granted at edge k+1. dst_valid_out is high after edge k+1.
- Throughput: 1 word per cycle sustained when dst_ready_in=1.
- Backpressure: while dst_valid_out & ~dst_ready_in, dst_data_out and dst_chan_out hold stable and no grant occurs.
- A push and a pop on the same FIFO in the same cycle leave the level unchanged. A full FIFO cannot push that cycle, because ready was already low.
- FIFO pointers wrap modulo FIFO_DEPTH. full = (level==FIFO_DEPTH), empty = (level==0).
- arst mid-transfer: all outputs go to reset values asynchronously and in-flight data is discarded.
- irq follows a STALL set by one cycle.

## Test plan
- Reset, then write CTRL=0x1 and CH_EN=0x1. Push 0x1234 on ch0 at edge k -> dst_valid_out=1, data 0x1234, chan 0 after edge k+1; reading 0x4 returns 0 after the pop.
- Round-robin, NUM_CH=4, all channels enabled and continuously valid with values 0xA0+i, dst_ready_in=1 -> output chan sequence 0,1,2,3,0,1,… at one word per cycle.
- MODE=1 with ch1 and ch3 backlogged -> ch1 drains fully before any ch3 word appears.
- CH_EN=0x1, drive ch0 for 10 cycles with dst_ready_in=0 -> level reaches 8, then src_ready_out[0]=0. STALL reads 0x1; with IRQ_EN=0x1, irq=1. Writing 0x1 to STALL with ch0 valid deasserted clears STALL and irq drops the next cycle.
- Hold dst_ready_in=0 with OREG valid, then write FLUSH -> dst_valid_out=0 and all levels read 0 on the next cycle; STALL is unchanged.
- Assert arst mid-stream with levels at 3 and 5 -> all outputs 0 immediately; after release all registers read 0.

Source files
------------

// File: rtl/dsp_stream_arbiter_if.sv
// Register window and stream handshake bundle for the DSP stream arbiter.
// master = register/stream driver side, slave = the arbiter itself.
interface dsp_stream_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned ADDR_WIDTH = 5
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [ADDR_WIDTH-1:0]        addr;
    logic                         write_en;
    logic [DATA_WIDTH-1:0]        wdata;
    logic [DATA_WIDTH-1:0]        rdata;
    logic [NUM_CH*DATA_WIDTH-1:0] src_data_in;
    logic [NUM_CH-1:0]            src_valid_in;
    logic [NUM_CH-1:0]            src_ready_out;
    logic [DATA_WIDTH-1:0]        dst_data_out;
    logic [CH_W-1:0]              dst_chan_out;
    logic                         dst_valid_out;
    logic                         dst_ready_in;
    logic                         irq;

    modport master (
        output addr, write_en, wdata, src_data_in, src_valid_in, dst_ready_in,
        input  rdata, src_ready_out, dst_data_out, dst_chan_out, dst_valid_out, irq
    );

    modport slave (
        input  addr, write_en, wdata, src_data_in, src_valid_in, dst_ready_in,
        output rdata, src_ready_out, dst_data_out, dst_chan_out, dst_valid_out, irq
    );
endinterface

// File: rtl/dsp_stream_arbiter.sv
// NUM_CH buffered input channels merged onto one tagged ready/valid stream
// by round-robin or fixed-priority arbitration, with a small register window.
module dsp_stream_arbiter #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input logic                 clk,
    input logic                 arst,
    dsp_stream_arbiter_if.slave bus
);
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);

    logic                  ctrl_en, ctrl_mode;
    logic [NUM_CH-1:0]     ch_en, stall, irq_en;
    logic [DATA_WIDTH-1:0] mem [NUM_CH][FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr [NUM_CH];
    logic [PTR_W-1:0]      rd_ptr [NUM_CH];
    logic [LVL_W-1:0]      level  [NUM_CH];
    logic [NUM_CH-1:0]     full, eligible, push, pop, stall_set;
    logic [CH_W-1:0]       last_grant, gnt_idx, rr_cand;
    logic                  grant;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  oreg_valid;
    logic [DATA_WIDTH-1:0] oreg_data;
    logic [CH_W-1:0]       oreg_chan;
    logic                  irq_q;
    logic [DATA_WIDTH-1:0] rdata_c;
    logic                  wr_ctrl, wr_chen, wr_stall, wr_irqen, flush;
    logic                  unused_wdata;

    assign wr_ctrl  = bus.write_en && (bus.addr == ADDR_WIDTH'(0));
    assign wr_chen  = bus.write_en && (bus.addr == ADDR_WIDTH'(1));
    assign wr_stall = bus.write_en && (bus.addr == ADDR_WIDTH'(2));
    assign wr_irqen = bus.write_en && (bus.addr == ADDR_WIDTH'(3));
    assign flush    = wr_ctrl && bus.wdata[2];
    assign unused_wdata = ^bus.wdata;

    // Per-channel status; ready depends only on registered state.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            full[i]      = (level[i] == LVL_W'(FIFO_DEPTH));
            eligible[i]  = ch_en[i] && (level[i] != '0);
            stall_set[i] = bus.src_valid_in[i] && ch_en[i] && (level[i] == LVL_W'(FIFO_DEPTH));
        end
    end

    assign bus.src_ready_out = {NUM_CH{ctrl_en}} & ch_en & ~full;
    assign push              = bus.src_valid_in & bus.src_ready_out;
    assign grant             = ctrl_en && (!oreg_valid || bus.dst_ready_in) && (|eligible);

    // Winner select: descending scan so the highest-precedence candidate is written last.
    always_comb begin
        gnt_idx = '0;
        rr_cand = '0;
        if (ctrl_mode) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (eligible[i]) gnt_idx = CH_W'(i);
            end
        end else begin
            for (int off = NUM_CH; off >= 1; off--) begin
                rr_cand = CH_W'((32'(last_grant) + 32'(off)) % NUM_CH);
                if (eligible[rr_cand]) gnt_idx = rr_cand;
            end
        end
    end

    always_comb begin
        head_data = '0;
        pop       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt_idx == CH_W'(i)) begin
                head_data = mem[i][rd_ptr[i]];
                pop[i]    = grant;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (push[i]) mem[i][wr_ptr[i]] <= bus.src_data_in[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                level[i]  <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                level[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                if (push[i] && !pop[i])      level[i] <= level[i] + LVL_W'(1);
                else if (pop[i] && !push[i]) level[i] <= level[i] - LVL_W'(1);
            end
        end
    end

    // Output register; flush is the only non-handshake way valid can drop.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            oreg_valid <= 1'b0;
            oreg_data  <= '0;
            oreg_chan  <= '0;
            last_grant <= CH_W'(NUM_CH - 1);
        end else if (flush) begin
            oreg_valid <= 1'b0;
            last_grant <= CH_W'(NUM_CH - 1);
        end else if (grant) begin
            oreg_valid <= 1'b1;
            oreg_data  <= head_data;
            oreg_chan  <= gnt_idx;
            last_grant <= gnt_idx;
        end else if (oreg_valid && bus.dst_ready_in) begin
            oreg_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            ctrl_en   <= 1'b0;
            ctrl_mode <= 1'b0;
            ch_en     <= '0;
            irq_en    <= '0;
            stall     <= '0;
            irq_q     <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en   <= bus.wdata[0];
                ctrl_mode <= bus.wdata[1];
            end
            if (wr_chen)  ch_en  <= bus.wdata[NUM_CH-1:0];
            if (wr_irqen) irq_en <= bus.wdata[NUM_CH-1:0];
            stall <= (stall & ~(wr_stall ? bus.wdata[NUM_CH-1:0] : NUM_CH'(0))) | stall_set;
            irq_q <= |(stall & irq_en);
        end
    end

    always_comb begin
        rdata_c = '0;
        case (bus.addr)
            ADDR_WIDTH'(0): rdata_c = DATA_WIDTH'({ctrl_mode, ctrl_en});
            ADDR_WIDTH'(1): rdata_c = DATA_WIDTH'(ch_en);
            ADDR_WIDTH'(2): rdata_c = DATA_WIDTH'(stall);
            ADDR_WIDTH'(3): rdata_c = DATA_WIDTH'(irq_en);
            default:        rdata_c = '0;
        endcase
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.addr == ADDR_WIDTH'(4 + i)) rdata_c = DATA_WIDTH'(level[i]);
        end
    end

    assign bus.rdata         = rdata_c;
    assign bus.dst_valid_out = oreg_valid;
    assign bus.dst_data_out  = oreg_data;
    assign bus.dst_chan_out  = oreg_chan;
    assign bus.irq           = irq_q;
endmodule
